// File: rtl/program_encoder_pkg.sv
// Shared RV32I encoding constants and types for the program encoder and the core decoder.
// Defining PROGRAM_ENCODER_NOP_PAD_EN adds the PAD state used for trailing NOP padding.
package program_encoder_pkg;

    typedef enum logic [4:0] {
        ENC_ADD, ENC_SUB, ENC_SLL, ENC_SRL, ENC_SRA, ENC_XOR, ENC_OR, ENC_AND, ENC_SLT, ENC_SLTU,
        ENC_ADDI, ENC_SLLI, ENC_SRLI, ENC_SRAI, ENC_XORI, ENC_ORI, ENC_ANDI, ENC_SLTI, ENC_SLTIU,
        ENC_LUI, ENC_LW, ENC_SW,
        ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU
    } encoder_op_type;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
        , ST_PAD
`endif
    } encoder_state_t;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

    // A value fits a signed N-bit field when all bits from N-1 upward agree.
    function automatic logic fits_simm12(input logic [31:0] v);
        return (v[31:11] == '0) || (v[31:11] == '1);
    endfunction

    function automatic logic fits_branch(input logic [31:0] v);
        return ((v[31:12] == '0) || (v[31:12] == '1)) && !v[0];
    endfunction

endpackage

// File: rtl/program_encoder_instr_packer.sv
// Combinational packer: symbolic RV32I request to a 32-bit instruction word plus a legality flag.
module instr_packer
    import program_encoder_pkg::*;
(
    input  encoder_op_type op,
    input  logic [4:0]     rd,
    input  logic [4:0]     rs1,
    input  logic [4:0]     rs2,
    input  logic [31:0]    imm,
    output logic [31:0]    word,
    output logic           legal
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    always_comb begin
        funct3 = F3_ADD_SUB;
        funct7 = F7_BASE;
        case (op)
            ENC_SUB:                 funct7 = F7_ALT;
            ENC_SLL, ENC_SLLI:       funct3 = F3_SLL;
            ENC_SRL, ENC_SRLI:       funct3 = F3_SRL_SRA;
            ENC_SRA, ENC_SRAI: begin
                funct3 = F3_SRL_SRA;
                funct7 = F7_ALT;
            end
            ENC_XOR, ENC_XORI:       funct3 = F3_XOR;
            ENC_OR, ENC_ORI:         funct3 = F3_OR;
            ENC_AND, ENC_ANDI:       funct3 = F3_AND;
            ENC_SLT, ENC_SLTI:       funct3 = F3_SLT;
            ENC_SLTU, ENC_SLTIU:     funct3 = F3_SLTU;
            ENC_LW, ENC_SW:          funct3 = F3_WORD;
            ENC_BEQ:                 funct3 = F3_BEQ;
            ENC_BNE:                 funct3 = F3_BNE;
            ENC_BLT:                 funct3 = F3_BLT;
            ENC_BGE:                 funct3 = F3_BGE;
            ENC_BLTU:                funct3 = F3_BLTU;
            ENC_BGEU:                funct3 = F3_BGEU;
            default: ;
        endcase
    end

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op)
            ENC_ADD, ENC_SUB, ENC_SLL, ENC_SRL, ENC_SRA,
            ENC_XOR, ENC_OR, ENC_AND, ENC_SLT, ENC_SLTU:
                word = {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
            ENC_ADDI, ENC_XORI, ENC_ORI, ENC_ANDI, ENC_SLTI, ENC_SLTIU: begin
                word  = {imm[11:0], rs1, funct3, rd, OPCODE_OP_IMM};
                legal = fits_simm12(imm);
            end
            ENC_SLLI, ENC_SRLI, ENC_SRAI: begin
                word  = {funct7, imm[4:0], rs1, funct3, rd, OPCODE_OP_IMM};
                legal = (imm[31:5] == '0);
            end
            ENC_LUI: begin
                word  = {imm[31:12], rd, OPCODE_LUI};
                legal = (imm[11:0] == '0);
            end
            ENC_LW: begin
                word  = {imm[11:0], rs1, funct3, rd, OPCODE_LOAD};
                legal = fits_simm12(imm);
            end
            ENC_SW: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPCODE_STORE};
                legal = fits_simm12(imm);
            end
            ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPCODE_BRANCH};
                legal = fits_branch(imm);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_encoder.sv
// Program encoder top: handshake, FSM and sequential instruction-memory writer.
// Defining PROGRAM_ENCODER_NOP_PAD_EN appends NOP_PAD NOP words after each program.
module program_encoder
    import program_encoder_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 10
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
    , parameter int NOP_PAD = 4
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       finish,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  encoder_op_type             req_op,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_rs1,
    input  logic [4:0]                 req_rs2,
    input  logic [31:0]                req_imm,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [IMEM_ADDR_WIDTH:0]   word_count,
    output logic                       busy,
    output logic                       done,
    output logic                       err_illegal,
    output logic                       err_overflow
);

    localparam logic [IMEM_ADDR_WIDTH:0] CAPACITY  = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};
    localparam logic [IMEM_ADDR_WIDTH:0] LAST_SLOT = CAPACITY - 1'b1;

    encoder_state_t state;
    logic [31:0]    pack_word;
    logic           pack_legal;
    logic           accept;

`ifdef PROGRAM_ENCODER_NOP_PAD_EN
    localparam int PAD_W = $clog2(NOP_PAD + 2);
    logic [PAD_W-1:0] pad_count;
`endif

    instr_packer u_packer (
        .op    (req_op),
        .rd    (req_rd),
        .rs1   (req_rs1),
        .rs2   (req_rs2),
        .imm   (req_imm),
        .word  (pack_word),
        .legal (pack_legal)
    );

    assign req_ready = (state == ST_RUN) && (word_count < CAPACITY);
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);

    // Overflow takes priority over finish: the last slot was just filled, so nothing more fits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
            pad_count    <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_RUN;
                        word_count   <= '0;
                        done         <= 1'b0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
                        pad_count    <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (pack_legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_count[IMEM_ADDR_WIDTH-1:0];
                            imem_wdata <= pack_word;
                            word_count <= word_count + 1'b1;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                    if (accept && pack_legal && (word_count == LAST_SLOT)) begin
                        err_overflow <= 1'b1;
                        state        <= ST_DONE;
                        done         <= 1'b1;
                    end else if (finish) begin
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
                        if (NOP_PAD == 0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_PAD;
                        end
`else
                        state <= ST_DONE;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
                ST_PAD: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_count[IMEM_ADDR_WIDTH-1:0];
                    imem_wdata <= NOP_INSTRUCTION;
                    word_count <= word_count + 1'b1;
                    pad_count  <= pad_count + 1'b1;
                    if (word_count == LAST_SLOT) begin
                        err_overflow <= 1'b1;
                        state        <= ST_DONE;
                        done         <= 1'b1;
                    end else if (pad_count == PAD_W'(NOP_PAD - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_encoder.sv
// Self-checking bench for program_encoder: scoreboard of expected memory writes plus status checks.
// Honors PROGRAM_ENCODER_NOP_PAD_EN by expecting trailing NOP writes after each finish.
module tb_program_encoder;
    import program_encoder_pkg::*;

    localparam int AW   = 3;
    localparam int CAP  = 1 << AW;
    localparam int NPAD = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           finish = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    encoder_op_type req_op = ENC_ADD;
    logic [4:0]     req_rd = '0;
    logic [4:0]     req_rs1 = '0;
    logic [4:0]     req_rs2 = '0;
    logic [31:0]    req_imm = '0;
    logic           imem_we;
    logic [AW-1:0]  imem_addr;
    logic [31:0]    imem_wdata;
    logic [AW:0]    word_count;
    logic           busy;
    logic           done;
    logic           err_illegal;
    logic           err_overflow;

    program_encoder #(
        .IMEM_ADDR_WIDTH(AW)
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
        , .NOP_PAD(NPAD)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .finish       (finish),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        bit          check_lat;
    } exp_write_t;

    exp_write_t exp_q[$];
    int cyc = 0;
    int exp_count = 0;
    int checks_total = 0;
    int checks_passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // Every write the DUT makes must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            check_output("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_write_t e;
                e = exp_q.pop_front();
                check_output("write_addr", 32'(imem_addr), e.addr);
                check_output("write_data", imem_wdata, e.data);
                if (e.check_lat) check_output("write_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push_pads();
`ifdef PROGRAM_ENCODER_NOP_PAD_EN
        for (int i = 0; i < NPAD && exp_count < CAP; i++) begin
            exp_q.push_back('{32'(exp_count), NOP_INSTRUCTION, 0, 1'b0});
            exp_count++;
        end
`endif
    endtask

    task automatic apply_stimulus(input encoder_op_type op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  input logic [31:0] exp_word, input bit exp_legal, input bit with_finish);
        int waited = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        while (waited < 20) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
        end
        if (!req_ready) begin
            check_output("req_ready_wait", 32'(req_ready), 1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            return;
        end
        finish = with_finish;
        if (exp_legal) begin
            exp_q.push_back('{32'(exp_count), exp_word, cyc + 1, 1'b1});
            exp_count++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        finish    = 1'b0;
        if (with_finish) push_pads();
    endtask

    task automatic begin_program();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check_output("start_busy", 32'(busy), 1);
        check_output("start_count", 32'(word_count), 0);
        check_output("start_done_clr", 32'(done), 0);
        check_output("start_ill_clr", 32'(err_illegal), 0);
        check_output("start_ovf_clr", 32'(err_overflow), 0);
        @(posedge clk); #1;
    endtask

    task automatic finish_program();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        push_pads();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(done), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output({tag, "_idle"}, 32'(busy), 0);
        check_output({tag, "_sticky"}, 32'(done), 1);
        check_output({tag, "_count"}, 32'(word_count), 32'(exp_count));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_we", 32'(imem_we), 0);
        check_output("reset_addr", 32'(imem_addr), 0);
        check_output("reset_wdata", imem_wdata, 0);
        check_output("reset_count", 32'(word_count), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_done", 32'(done), 0);
        check_output("reset_ill", 32'(err_illegal), 0);
        check_output("reset_ovf", 32'(err_overflow), 0);
        check_output("reset_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single ADDI program");
        begin_program();
        apply_stimulus(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, 1'b0);
        finish_program();
        wait_done("t1_done");
        check_output("t1_no_illegal", 32'(err_illegal), 0);

        $display("[TB] back-to-back SUB, SW, LW");
        begin_program();
        apply_stimulus(ENC_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b1, 1'b0);
        apply_stimulus(ENC_SW, 5'd0, 5'd1, 5'd2, 32'd4, 32'h0020A223, 1'b1, 1'b0);
        apply_stimulus(ENC_LW, 5'd4, 5'd2, 5'd0, 32'hFFFFFFF8, 32'hFF812203, 1'b1, 1'b0);
        finish_program();
        wait_done("t2_done");

        $display("[TB] branches and LUI with finish on last request");
        begin_program();
        apply_stimulus(ENC_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b1, 1'b0);
        apply_stimulus(ENC_BNE, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFC, 32'hFE009EE3, 1'b1, 1'b0);
        apply_stimulus(ENC_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1, 1'b1);
        wait_done("t3_done");

        $display("[TB] illegal immediates");
        begin_program();
        apply_stimulus(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b0, 1'b0);
        apply_stimulus(ENC_SLLI, 5'd1, 5'd0, 5'd0, 32'd32, 32'h0, 1'b0, 1'b0);
        apply_stimulus(ENC_BNE, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("t4_count", 32'(word_count), 0);
        check_output("t4_illegal", 32'(err_illegal), 1);
        check_output("t4_busy", 32'(busy), 1);
        check_output("t4_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        apply_stimulus(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b1, 1'b0);
        apply_stimulus(ENC_SRAI, 5'd2, 5'd3, 5'd0, 32'd4, 32'h4041D113, 1'b1, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_output("t4_start_ignored_count", 32'(word_count), 2);
        check_output("t4_start_ignored_ill", 32'(err_illegal), 1);
        @(posedge clk); #1;
        finish_program();
        wait_done("t4_done");

        $display("[TB] capacity overflow");
        begin_program();
        for (int i = 0; i < CAP; i++) begin
            apply_stimulus(ENC_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i),
                           (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13, 1'b1, 1'b0);
        end
        @(negedge clk);
        check_output("t5_ready_low", 32'(req_ready), 0);
        check_output("t5_overflow", 32'(err_overflow), 1);
        check_output("t5_count", 32'(word_count), 32'(CAP));
        @(posedge clk); #1;
        wait_done("t5_done");

        $display("[TB] reset during write");
        begin_program();
        req_valid = 1'b1;
        req_op    = ENC_ADDI;
        req_rd    = 5'd7;
        req_rs1   = 5'd0;
        req_imm   = 32'd9;
        @(negedge clk);
        check_output("t6_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("t6_we_before_reset", 32'(imem_we), 1);
        rst = 1'b0;
        #1;
        check_output("t6_we", 32'(imem_we), 0);
        check_output("t6_wdata", imem_wdata, 0);
        check_output("t6_count", 32'(word_count), 0);
        check_output("t6_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        repeat (3) @(negedge clk);
        check_output("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
